mem_responder: RTL and testbench

- Word-serial main-memory model: the responder end of the cache refill protocol (mem_req/mem_adr -> mem_ack/mem_dat).
- Serves a 4-word line critical-word-first, in wrap order, after a fixed read latency.
- Absorbs single-word victim writebacks on a separate port.
- Sits below the 4-way cache, in simulation and FPGA bring-up, as the backing store.

---
 rtl/mem_responder.sv | 160 ++++++++++++++++
 tb/tb_mem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: word-serial main-memory model backing the 4-way cache.
// Serves a 4-word line critical-word-first in wrap order after a fixed read
// latency, and absorbs single-word victim writebacks on a separate port.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   mem_req_i      refill request (level, held for the whole transaction)
//   mem_adr_i      byte address of the critical word
//   mem_ack_o      one beat valid
//   mem_dat_o      beat data
//   mem_word_o     word offset of the current beat
//   mem_last_o     fourth beat of the line
//   busy_o         FSM not idle
//   wb_req_i       writeback strobe, one word per cycle
//   wb_adr_i       writeback line byte address (bits [3:0] ignored)
//   wb_word_i      writeback word offset within the line
//   wb_dat_i       writeback data
//   wb_ack_o       writeback done, one cycle after the strobe
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no transaction; a request is latched here
// WAIT  | read latency down-counter running
// BURST | one beat per edge; beat 0 already registered on entry
// HOLD  | line delivered, waiting for the request to drop

module mem_responder #(
  parameter int WORD_WIDTH     = 32,
  parameter int ADR_WIDTH      = 32,
  parameter int MEM_DEPTH_LOG2 = 12,
  parameter int WORD_NUM       = 4,
  parameter int READ_LATENCY   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req_i,
  input  logic [ADR_WIDTH-1:0]  mem_adr_i,
  output logic                  mem_ack_o,
  output logic [WORD_WIDTH-1:0] mem_dat_o,
  output logic [1:0]            mem_word_o,
  output logic                  mem_last_o,
  output logic                  busy_o,
  input  logic                  wb_req_i,
  input  logic [ADR_WIDTH-1:0]  wb_adr_i,
  input  logic [1:0]            wb_word_i,
  input  logic [WORD_WIDTH-1:0] wb_dat_i,
  output logic                  wb_ack_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int LINE_BITS = MEM_DEPTH_LOG2 - 2;

  state_t state_q, state_d;

  // Only the line bits that index storage are kept; higher bits alias.
  logic [LINE_BITS-1:0] base_q;
  logic [1:0]           start_q;
  logic [1:0]           beat_q;
  logic [3:0]           lat_q;

  logic                  beat_fire;
  logic [1:0]            beat_idx;
  logic [1:0]            beat_word;
  logic [WORD_WIDTH-1:0] rd_data;

  logic [WORD_WIDTH-1:0]     mem [0:(1<<MEM_DEPTH_LOG2)-1];
  logic [MEM_DEPTH_LOG2-1:0] wb_idx;

  logic unused_adr;
  assign unused_adr = ^{mem_adr_i[ADR_WIDTH-1:MEM_DEPTH_LOG2+2], mem_adr_i[1:0],
                        wb_adr_i[ADR_WIDTH-1:MEM_DEPTH_LOG2+2], wb_adr_i[3:0]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (mem_req_i) state_d = WAIT;
      WAIT: begin
        if (!mem_req_i)       state_d = IDLE;
        else if (lat_q == '0) state_d = BURST;
      end
      BURST: begin
        if (!mem_req_i)          state_d = IDLE;
        else if (beat_q == 2'd3) state_d = HOLD;
      end
      HOLD:  if (!mem_req_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / beat decode. An abort (request low) suppresses the beat.
  always_comb begin
    busy_o    = (state_q != IDLE);
    beat_fire = 1'b0;
    beat_idx  = 2'd0;
    case (state_q)
      WAIT:  beat_fire = mem_req_i && (lat_q == '0);
      BURST: begin
        beat_fire = mem_req_i && (beat_q != 2'd3);
        beat_idx  = beat_q + 2'd1;
      end
      default: ;
    endcase
    beat_word = start_q + beat_idx;
  end

  // Combinational read sampled at the edge gives read-first against a
  // same-edge writeback.
  assign rd_data = mem[{base_q, beat_word}];
  assign wb_idx  = {wb_adr_i[MEM_DEPTH_LOG2+1:4], wb_word_i};

  // Storage is deliberately not reset; a strobe coincident with reset is dropped.
  always_ff @(posedge clk) begin
    if (wb_req_i && !rst) mem[wb_idx] <= wb_dat_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_ack_o  <= 1'b0;
      mem_dat_o  <= '0;
      mem_word_o <= 2'd0;
      mem_last_o <= 1'b0;
      wb_ack_o   <= 1'b0;
      base_q     <= '0;
      start_q    <= 2'd0;
      beat_q     <= 2'd0;
      lat_q      <= '0;
    end else begin
      wb_ack_o   <= wb_req_i;
      mem_ack_o  <= beat_fire;
      mem_last_o <= beat_fire && (beat_idx == 2'd3);
      if (beat_fire) begin
        mem_dat_o  <= rd_data;
        mem_word_o <= beat_word;
        beat_q     <= beat_idx;
      end
      if (state_q == IDLE && mem_req_i) begin
        base_q  <= mem_adr_i[MEM_DEPTH_LOG2+1:4];
        start_q <= mem_adr_i[3:2];
        beat_q  <= 2'd0;
        lat_q   <= 4'(READ_LATENCY - 1);
      end else if (state_q == WAIT && lat_q != '0) begin
        lat_q <= lat_q - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req3, req1;
  logic [31:0] adr3, adr1;
  logic        ack3, ack1, last3, last1, busy3, busy1, wback3, wback1;
  logic [31:0] dat3, dat1;
  logic [1:0]  word3, word1;
  logic        wb_req;
  logic [31:0] wb_adr, wb_dat;
  logic [1:0]  wb_word;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [0:4095];
  logic [31:0] first_dat;

  always #5 clk = ~clk;

  mem_responder #(.READ_LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .mem_req_i(req3), .mem_adr_i(adr3),
    .mem_ack_o(ack3), .mem_dat_o(dat3), .mem_word_o(word3), .mem_last_o(last3),
    .busy_o(busy3), .wb_req_i(wb_req), .wb_adr_i(wb_adr), .wb_word_i(wb_word),
    .wb_dat_i(wb_dat), .wb_ack_o(wback3));

  mem_responder #(.READ_LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .mem_req_i(req1), .mem_adr_i(adr1),
    .mem_ack_o(ack1), .mem_dat_o(dat1), .mem_word_o(word1), .mem_last_o(last1),
    .busy_o(busy1), .wb_req_i(wb_req), .wb_adr_i(wb_adr), .wb_word_i(wb_word),
    .wb_dat_i(wb_dat), .wb_ack_o(wback1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int midx(input logic [31:0] adr, input logic [1:0] w);
    return int'({adr[13:4], w});
  endfunction

  task automatic wb_write(input logic [31:0] adr, input logic [1:0] w, input logic [31:0] d);
    wb_req = 1'b1; wb_adr = adr; wb_word = w; wb_dat = d;
    step();
    chk("wb_ack", {31'd0, wback3}, 32'd1);
    wb_req = 1'b0;
    model[midx(adr, w)] = d;
  endtask

  // Full burst on the READ_LATENCY=3 instance, through HOLD back to IDLE.
  task automatic rd3(input logic [31:0] adr);
    logic [1:0] w;
    req3 = 1'b1; adr3 = adr;
    step();
    chk("rd3_busy_e0", {31'd0, busy3}, 32'd1);
    adr3 = 32'hFFFF_FFFF;
    step(); chk("rd3_ack_e1", {31'd0, ack3}, 32'd0);
    step(); chk("rd3_ack_e2", {31'd0, ack3}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      w = adr[3:2] + 2'(k);
      chk("rd3_ack", {31'd0, ack3}, 32'd1);
      chk("rd3_word", {30'd0, word3}, {30'd0, w});
      chk("rd3_dat", dat3, model[midx(adr, w)]);
      chk("rd3_last", {31'd0, last3}, (k == 3) ? 32'd1 : 32'd0);
      if (k == 0) first_dat = dat3;
    end
    step();
    chk("rd3_hold_ack", {31'd0, ack3}, 32'd0);
    chk("rd3_hold_busy", {31'd0, busy3}, 32'd1);
    req3 = 1'b0;
    step();
    chk("rd3_idle_busy", {31'd0, busy3}, 32'd0);
  endtask

  task automatic rd1(input logic [31:0] adr);
    logic [1:0] w;
    req1 = 1'b1; adr1 = adr;
    step();
    chk("rd1_ack_e0", {31'd0, ack1}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      w = adr[3:2] + 2'(k);
      chk("rd1_ack", {31'd0, ack1}, 32'd1);
      chk("rd1_word", {30'd0, word1}, {30'd0, w});
      chk("rd1_dat", dat1, model[midx(adr, w)]);
      chk("rd1_last", {31'd0, last1}, (k == 3) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; req3 = 1'b0; req1 = 1'b0; adr3 = '0; adr1 = '0;
    wb_req = 1'b0; wb_adr = '0; wb_word = '0; wb_dat = '0;
    for (int i = 0; i < 4096; i++) model[i] = 32'hx;
    step(); step();
    rst = 1'b0;
    chk("rst_ack", {31'd0, ack3}, 32'd0);
    chk("rst_dat", dat3, 32'd0);
    chk("rst_word", {30'd0, word3}, 32'd0);
    chk("rst_last", {31'd0, last3}, 32'd0);
    chk("rst_busy", {31'd0, busy3}, 32'd0);
    chk("rst_wback", {31'd0, wback3}, 32'd0);

    // Preload, back-to-back strobes
    wb_write(32'h100, 2'd0, 32'hA0);
    wb_write(32'h100, 2'd1, 32'hA1);
    wb_write(32'h100, 2'd2, 32'hA2);
    wb_write(32'h100, 2'd3, 32'hA3);
    step();
    chk("wb_ack_drop", {31'd0, wback3}, 32'd0);

    // Latency 3, critical word 2: A2,A3,A0,A1
    rd3(32'h108);
    chk("rd3_first_A2", first_dat, 32'hA2);

    // Latency 1 from 0x100, held request must not restart
    rd1(32'h100);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rd1_held_noack", {31'd0, ack1}, 32'd0);
    end
    chk("rd1_held_busy", {31'd0, busy1}, 32'd1);
    req1 = 1'b0;
    step();
    chk("rd1_idle", {31'd0, busy1}, 32'd0);
    rd1(32'h100);
    req1 = 1'b0;
    step(); step();

    // Writeback two edges before beat 3 -> new data
    req1 = 1'b1; adr1 = 32'h100;
    step();               // E0
    step();               // E1: beat 0
    wb_req = 1'b1; wb_adr = 32'h100; wb_word = 2'd3; wb_dat = 32'hBEEF;
    step();               // E2: beat 1, write lands
    wb_req = 1'b0;
    step();               // E3: beat 2
    step();               // E4: beat 3
    chk("early_wb_dat", dat1, 32'hBEEF);
    chk("early_wb_last", {31'd0, last1}, 32'd1);
    req1 = 1'b0;
    step(); step();
    wb_write(32'h100, 2'd3, 32'hA3);

    // Writeback at the exact beat-3 edge -> old data
    req1 = 1'b1; adr1 = 32'h100;
    step(); step(); step(); step();   // E0..E3
    wb_req = 1'b1; wb_adr = 32'h100; wb_word = 2'd3; wb_dat = 32'hBEEF;
    step();                           // E4: beat 3 and write
    wb_req = 1'b0;
    chk("same_edge_dat", dat1, 32'hA3);
    chk("same_edge_word", {30'd0, word1}, 32'd3);
    req1 = 1'b0;
    step();
    wb_write(32'h100, 2'd3, 32'hA3);

    // Abort after beat 1
    req3 = 1'b1; adr3 = 32'h100;
    step(); step(); step(); step();   // E0..E3 (beat 0)
    step();                           // E4 beat 1
    chk("abort_beat1_ack", {31'd0, ack3}, 32'd1);
    chk("abort_beat1_dat", dat3, 32'hA1);
    req3 = 1'b0;
    step();
    chk("abort_ack", {31'd0, ack3}, 32'd0);
    chk("abort_last", {31'd0, last3}, 32'd0);
    chk("abort_busy", {31'd0, busy3}, 32'd0);
    step();
    chk("abort_stay", {31'd0, ack3}, 32'd0);
    rd3(32'h104);
    chk("rd3_first_A1", first_dat, 32'hA1);

    // Reset during WAIT
    req3 = 1'b1; adr3 = 32'h108;
    step(); step();
    rst = 1'b1; req3 = 1'b0;
    step();
    chk("rstw_ack", {31'd0, ack3}, 32'd0);
    chk("rstw_busy", {31'd0, busy3}, 32'd0);
    rst = 1'b0;
    step();

    // Reset during BURST with a coincident writeback that must be dropped
    req3 = 1'b1; adr3 = 32'h108;
    step(); step(); step(); step(); step();   // beat 1 at E4
    chk("rstb_pre_ack", {31'd0, ack3}, 32'd1);
    rst = 1'b1; req3 = 1'b0;
    wb_req = 1'b1; wb_adr = 32'h100; wb_word = 2'd2; wb_dat = 32'hDEAD;
    step();
    wb_req = 1'b0;
    chk("rstb_ack", {31'd0, ack3}, 32'd0);
    chk("rstb_dat", dat3, 32'd0);
    chk("rstb_word", {30'd0, word3}, 32'd0);
    chk("rstb_last", {31'd0, last3}, 32'd0);
    chk("rstb_busy", {31'd0, busy3}, 32'd0);
    chk("rstb_wback", {31'd0, wback3}, 32'd0);
    rst = 1'b0;
    step();
    rd3(32'h108);
    chk("post_rst_A2", first_dat, 32'hA2);

    // Address aliasing modulo depth
    wb_write(32'h4008, 2'd2, 32'h55);
    rd3(32'h0008);
    chk("alias_dat", first_dat, 32'h55);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
